dsi_lane_receiver: RTL and testbench

//  Receive-side decoder for the DSI test-pattern line driven by the DAC pattern generator.

---
 rtl/dsi_pkg.sv | 41 ++++
 rtl/dsi_sync2.sv | 26 ++
 rtl/dsi_lane_receiver.sv | 249 ++++++++++++++++++++++++
 tb/tb_dsi_lane_receiver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_pkg.sv
// Shared DSI test-pattern definitions: line-state codes, receiver FSM encoding, error codes.
// Latency: n/a (package).
// Backpressure: n/a (package).
package dsi_pkg;

    // Line-state codes as produced by the comparator front end.
    localparam logic [1:0] LINE_DATA = 2'b00;
    localparam logic [1:0] LINE_GAP  = 2'b01;
    localparam logic [1:0] LINE_LP   = 2'b10;
    localparam logic [1:0] LINE_SYNC = 2'b11;

    // LP trailer pulse levels; one pulse is a low->high level edge.
    localparam logic [1:0] LVL_PULSE_LO = 2'b01;
    localparam logic [1:0] LVL_PULSE_HI = 2'b11;

    // Counter widths.
    localparam int RUN_W = 13;
    localparam int IDX_W = 11;
    localparam int TRL_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_DATA_RUN = 3'd2,
        ST_DATA_GAP = 3'd3,
        ST_TRAILER  = 3'd4
    } fsm_state_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_SYNC  = 3'd1;
    localparam logic [2:0] ERR_SHORT = 3'd2;
    localparam logic [2:0] ERR_LONG  = 3'd3;
    localparam logic [2:0] ERR_COUNT = 3'd4;
    localparam logic [2:0] ERR_PROTO = 3'd5;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dsi_sync2.sv
// Two-flop synchronizer for a W-bit bus of asynchronous pins.
// Latency: 2 clk cycles from pin to q.
// Backpressure: none; free-running.
//  Ports: clk, rst (async, active-high), d (async input bus), q (synchronized bus).
module dsi_sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dsi_lane_receiver.sv
// Decodes the DSI test-pattern line into sync, indexed data symbols and LP trailer.
// Latency: 3 clk from a pin change to the registered output it causes (2 sync + 1 out reg).
// Backpressure: none; outputs are single-cycle pulses that the consumer must take.
//  Ports: clk, rst (async active-high); line_state/line_level (async pins);
//  sym_valid/sym_level/sym_index (decoded symbol); frame_start/frame_done/frame_err pulses;
//  err_code (last error, cleared at frame_start); busy (FSM not idle); frame_count (good frames).
module dsi_lane_receiver
    import dsi_pkg::*;
#(
    parameter int NUM_DATA   = 1334,
    parameter int SYNC_MIN   = 500,
    parameter int SAMPLE_POS = 425,
    parameter int RUN_MAX    = 1000,
    parameter int GAP_MAX    = 200,
    parameter int TRAILER_N  = 541
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       line_state,
    input  logic [1:0]       line_level,
    output logic             sym_valid,
    output logic [1:0]       sym_level,
    output logic [IDX_W-1:0] sym_index,
    output logic             frame_start,
    output logic             frame_done,
    output logic             frame_err,
    output logic [2:0]       err_code,
    output logic             busy,
    output logic [15:0]      frame_count
);

    localparam logic [RUN_W-1:0] SYNC_LAST = RUN_W'(SYNC_MIN - 1);
    localparam logic [RUN_W-1:0] SAMPLE_C  = RUN_W'(SAMPLE_POS);
    localparam logic [RUN_W-1:0] RUN_MAX_C = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0] GAP_MAX_C = RUN_W'(GAP_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DATA - 1);
    localparam logic [TRL_W-1:0] TRL_MIN   = TRL_W'(TRAILER_N);

    logic [3:0]       sync_q;
    logic [1:0]       s_state;
    logic [1:0]       s_level;
    logic [1:0]       prev_state;
    logic [1:0]       prev_level;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_pos;
    logic [1:0]       lat_level;
    logic [IDX_W-1:0] idx;
    logic [TRL_W-1:0] trl_cnt;
    logic             lvl_edge;

    fsm_state_t state, state_n;
    logic       err_fire;
    logic [2:0] err_val;
    logic       emit_sym;
    logic       start;
    logic       done;
    logic       idx_inc;
    logic       trl_clr;
    logic       latch_lvl;

    dsi_sync2 #(.W(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({line_state, line_level}),
        .q   (sync_q)
    );

    assign s_state = sync_q[3:2];
    assign s_level = sync_q[1:0];

    // run_pos is the position of the current cycle within the current state run
    // (0 on the first cycle). At a state change, run_q still holds the final
    // position of the run that just ended, which is what the length checks use.
    assign run_pos  = (s_state != prev_state) ? '0 : sat_inc_run(run_q);
    assign lvl_edge = (prev_level == LVL_PULSE_LO) && (s_level == LVL_PULSE_HI);
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_n   = state;
        err_fire  = 1'b0;
        err_val   = ERR_NONE;
        emit_sym  = 1'b0;
        start     = 1'b0;
        done      = 1'b0;
        idx_inc   = 1'b0;
        trl_clr   = 1'b0;
        latch_lvl = 1'b0;

        case (state)
            ST_IDLE: begin
                if (s_state == LINE_SYNC && run_pos == SYNC_LAST)
                    state_n = ST_SYNC;
            end
            ST_SYNC: begin
                case (s_state)
                    LINE_DATA: begin
                        state_n = ST_DATA_RUN;
                        start   = 1'b1;
                    end
                    LINE_GAP, LINE_LP: begin
                        err_fire = 1'b1;
                        err_val  = ERR_SYNC;
                    end
                    default: ;
                endcase
            end
            ST_DATA_RUN: begin
                case (s_state)
                    LINE_DATA: begin
                        if (run_pos > RUN_MAX_C) begin
                            err_fire = 1'b1;
                            err_val  = ERR_LONG;
                        end else if (run_pos == SAMPLE_C) begin
                            latch_lvl = 1'b1;
                        end
                    end
                    LINE_GAP: begin
                        // A run whose last position equals SAMPLE_POS was sampled
                        // on its final cycle and is still a valid symbol.
                        if (run_q < SAMPLE_C) begin
                            err_fire = 1'b1;
                            err_val  = ERR_SHORT;
                        end else begin
                            emit_sym = 1'b1;
                            state_n  = ST_DATA_GAP;
                        end
                    end
                    default: begin
                        err_fire = 1'b1;
                        err_val  = ERR_PROTO;
                    end
                endcase
            end
            ST_DATA_GAP: begin
                case (s_state)
                    LINE_GAP: begin
                        if (run_pos > GAP_MAX_C) begin
                            err_fire = 1'b1;
                            err_val  = ERR_LONG;
                        end
                    end
                    LINE_DATA: begin
                        if (idx < IDX_LAST) begin
                            idx_inc = 1'b1;
                            state_n = ST_DATA_RUN;
                        end else begin
                            err_fire = 1'b1;
                            err_val  = ERR_COUNT;
                        end
                    end
                    LINE_LP: begin
                        if (idx == IDX_LAST) begin
                            trl_clr = 1'b1;
                            state_n = ST_TRAILER;
                        end else begin
                            err_fire = 1'b1;
                            err_val  = ERR_COUNT;
                        end
                    end
                    default: begin
                        err_fire = 1'b1;
                        err_val  = ERR_PROTO;
                    end
                endcase
            end
            ST_TRAILER: begin
                case (s_state)
                    LINE_LP: ;
                    LINE_SYNC: begin
                        // Back to IDLE on the first sync cycle; this same run may
                        // go on to qualify the next frame's sync.
                        if (trl_cnt >= TRL_MIN) begin
                            done    = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            err_fire = 1'b1;
                            err_val  = ERR_COUNT;
                        end
                    end
                    default: begin
                        err_fire = 1'b1;
                        err_val  = ERR_PROTO;
                    end
                endcase
            end
            default: state_n = ST_IDLE;
        endcase

        if (err_fire)
            state_n = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            prev_state  <= LINE_DATA;
            prev_level  <= 2'b00;
            run_q       <= '0;
            lat_level   <= 2'b00;
            idx         <= '0;
            trl_cnt     <= '0;
            sym_valid   <= 1'b0;
            sym_level   <= 2'b00;
            sym_index   <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
            frame_count <= '0;
        end else begin
            state      <= state_n;
            prev_state <= s_state;
            prev_level <= s_level;
            run_q      <= run_pos;

            if (latch_lvl)
                lat_level <= s_level;

            if (start)
                idx <= '0;
            else if (idx_inc)
                idx <= idx + 1'b1;

            if (trl_clr)
                trl_cnt <= '0;
            else if (state == ST_TRAILER && s_state == LINE_LP && lvl_edge && trl_cnt != '1)
                trl_cnt <= trl_cnt + 1'b1;

            sym_valid   <= emit_sym;
            frame_start <= start;
            frame_done  <= done;
            frame_err   <= err_fire;

            if (emit_sym) begin
                sym_level <= lat_level;
                sym_index <= idx;
            end

            if (start)
                err_code <= ERR_NONE;
            else if (err_fire)
                err_code <= err_val;

            if (done)
                frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_dsi_lane_receiver.sv
// Directed bench for dsi_lane_receiver with small frame parameters.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_dsi_lane_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  line_state;
    logic [1:0]  line_level;
    logic        sym_valid;
    logic [1:0]  sym_level;
    logic [10:0] sym_index;
    logic        frame_start;
    logic        frame_done;
    logic        frame_err;
    logic [2:0]  err_code;
    logic        busy;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    dsi_lane_receiver #(
        .NUM_DATA   (4),
        .SYNC_MIN   (8),
        .SAMPLE_POS (5),
        .RUN_MAX    (20),
        .GAP_MAX    (10),
        .TRAILER_N  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .line_state  (line_state),
        .line_level  (line_level),
        .sym_valid   (sym_valid),
        .sym_level   (sym_level),
        .sym_index   (sym_index),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .busy        (busy),
        .frame_count (frame_count)
    );

    // Scenario record. mode: 0 normal, 1 gap right after sync, 2 sync state instead of first gap.
    typedef struct {
        int sync_len;
        int mode;
        int nsym;
        int run0;
        int gap_len;
        int pulses;
        int e_start;
        int e_sym;
        int e_done;
        int e_err;
        int e_code;
        int e_fc;
    } vec_t;

    vec_t tbl [14];
    int   lv [4] = '{2, 1, 3, 0};

    int tests  = 0;
    int failed = 0;

    // Output monitor: cumulative pulse counts and the decoded symbol stream.
    int mon_start = 0;
    int mon_done  = 0;
    int mon_err   = 0;
    int q_lv [$];
    int q_ix [$];

    always @(negedge clk) begin
        if (sym_valid) begin
            q_lv.push_back(int'(sym_level));
            q_ix.push_back(int'(sym_index));
        end
        if (frame_start) mon_start++;
        if (frame_done)  mon_done++;
        if (frame_err)   mon_err++;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] st, input logic [1:0] lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            line_state = st;
            line_level = lvl;
        end
    endtask

    task automatic run_frame(input vec_t v);
        drive(2'b11, 2'b00, v.sync_len);
        if (v.mode == 1) begin
            drive(2'b01, 2'b00, 4);
        end else begin
            for (int s = 0; s < v.nsym; s++) begin
                drive(2'b00, 2'(lv[s % 4]), (s == 0) ? v.run0 : 12);
                if (s == 0 && v.mode == 2)
                    drive(2'b11, 2'b00, 3);
                else
                    drive(2'b01, 2'b00, v.gap_len);
            end
            drive(2'b10, 2'b00, 2);
            for (int p = 0; p < v.pulses; p++) begin
                drive(2'b10, 2'b01, 2);
                drive(2'b10, 2'b11, 2);
            end
            drive(2'b10, 2'b00, 2);
            drive(2'b11, 2'b00, 3);
        end
        drive(2'b10, 2'b00, 20);
    endtask

    task automatic chk_frame(input string tag, input int fc0, input int e_sym0);
        // Expects one full good frame since the given snapshots.
        chk({tag, "_sym_cnt"}, q_lv.size() - e_sym0, 4);
        for (int k = 0; k < 4 && e_sym0 + k < q_lv.size(); k++) begin
            chk($sformatf("%s_lvl%0d", tag, k), q_lv[e_sym0 + k], lv[k]);
            chk($sformatf("%s_idx%0d", tag, k), q_ix[e_sym0 + k], k);
        end
        chk({tag, "_fc"}, int'(frame_count), fc0);
    endtask

    initial begin
        //               sync mode nsym run0 gap pls | start sym done err code fc
        tbl[0]  = '{10, 0, 4, 12, 4, 3,  1, 4, 1, 0, 0, 1};  // good frame
        tbl[1]  = '{ 5, 0, 4, 12, 4, 3,  0, 0, 0, 0, 0, 1};  // short sync ignored
        tbl[2]  = '{10, 0, 4,  3, 4, 3,  1, 0, 0, 1, 2, 1};  // short data run
        tbl[3]  = '{10, 0, 4,  6, 4, 3,  1, 4, 1, 0, 0, 2};  // sample on last run cycle
        tbl[4]  = '{10, 0, 4,  5, 4, 3,  1, 0, 0, 1, 2, 2};  // one cycle too short
        tbl[5]  = '{10, 0, 3, 12, 4, 3,  1, 3, 0, 1, 4, 2};  // 3 symbols then LP
        tbl[6]  = '{10, 0, 5, 12, 4, 3,  1, 4, 0, 1, 4, 2};  // 5th symbol
        tbl[7]  = '{10, 0, 4, 12, 4, 2,  1, 4, 0, 1, 4, 2};  // 2 trailer pulses
        tbl[8]  = '{10, 0, 4, 25, 4, 3,  1, 0, 0, 1, 3, 2};  // data run too long
        tbl[9]  = '{10, 0, 4, 12, 12, 3, 1, 1, 0, 1, 3, 2};  // gap too long
        tbl[10] = '{10, 2, 4, 12, 4, 3,  1, 0, 0, 1, 5, 2};  // sync state inside data run
        tbl[11] = '{10, 1, 0, 12, 4, 3,  0, 0, 0, 1, 1, 2};  // gap right after sync
        tbl[12] = '{ 8, 0, 4, 12, 4, 3,  1, 4, 1, 0, 0, 3};  // minimum sync length
        tbl[13] = '{ 7, 0, 4, 12, 4, 3,  0, 0, 0, 0, 0, 3};  // sync one cycle short

        rst        = 1'b1;
        line_state = 2'b10;
        line_level = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_sym_valid",   int'(sym_valid),   0);
        chk("rst_sym_index",   int'(sym_index),   0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_frame_err",   int'(frame_err),   0);
        chk("rst_err_code",    int'(err_code),    0);
        chk("rst_busy",        int'(busy),        0);
        chk("rst_frame_count", int'(frame_count), 0);
        rst = 1'b0;
        drive(2'b10, 2'b00, 5);

        for (int i = 0; i < 14; i++) begin
            int s0, d0, e0, q0;
            s0 = mon_start;
            d0 = mon_done;
            e0 = mon_err;
            q0 = q_lv.size();
            run_frame(tbl[i]);
            chk($sformatf("v%0d_start", i), mon_start - s0, tbl[i].e_start);
            chk($sformatf("v%0d_done", i),  mon_done - d0,  tbl[i].e_done);
            chk($sformatf("v%0d_err", i),   mon_err - e0,   tbl[i].e_err);
            chk($sformatf("v%0d_nsym", i),  q_lv.size() - q0, tbl[i].e_sym);
            for (int k = 0; k < tbl[i].e_sym && q0 + k < q_lv.size(); k++) begin
                chk($sformatf("v%0d_lvl%0d", i, k), q_lv[q0 + k], lv[k % 4]);
                chk($sformatf("v%0d_idx%0d", i, k), q_ix[q0 + k], k);
            end
            chk($sformatf("v%0d_err_code", i), int'(err_code), tbl[i].e_code);
            chk($sformatf("v%0d_fcount", i),   int'(frame_count), tbl[i].e_fc);
            chk($sformatf("v%0d_busy", i),     int'(busy), 0);
        end

        // Short data run: error pulse lands 3 cycles after the gap reaches the pins.
        drive(2'b11, 2'b00, 10);
        drive(2'b00, 2'b01, 3);
        drive(2'b01, 2'b00, 1);
        @(negedge clk);
        @(negedge clk);
        chk("short_pre_err",  int'(frame_err), 0);
        chk("short_pre_busy", int'(busy),      1);
        @(negedge clk);
        chk("short_err",      int'(frame_err), 1);
        chk("short_err_code", int'(err_code),  2);
        chk("short_busy",     int'(busy),      0);
        chk("short_no_sym",   int'(sym_valid), 0);
        drive(2'b10, 2'b00, 20);

        // Symbol latency: sym_valid 3 cycles after the gap appears at the pins.
        drive(2'b11, 2'b00, 10);
        drive(2'b00, 2'b11, 12);
        drive(2'b01, 2'b00, 1);
        @(negedge clk);
        @(negedge clk);
        chk("lat_pre_sym", int'(sym_valid), 0);
        @(negedge clk);
        chk("lat_sym",       int'(sym_valid), 1);
        chk("lat_sym_level", int'(sym_level), 3);
        chk("lat_sym_index", int'(sym_index), 0);
        chk("lat_err_code",  int'(err_code),  0);
        drive(2'b01, 2'b00, 2);
        drive(2'b10, 2'b00, 20);
        chk("lat_gap_lp_err_code", int'(err_code), 4);

        // Reset in the middle of a data run, then a clean frame.
        drive(2'b11, 2'b00, 10);
        drive(2'b00, 2'b10, 8);
        chk("mid_busy", int'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",        int'(busy),        0);
        chk("mid_rst_err_code",    int'(err_code),    0);
        chk("mid_rst_frame_count", int'(frame_count), 0);
        chk("mid_rst_sym_valid",   int'(sym_valid),   0);
        chk("mid_rst_sym_level",   int'(sym_level),   0);
        chk("mid_rst_frame_done",  int'(frame_done),  0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(2'b10, 2'b00, 20);
        begin
            int q0, d0;
            q0 = q_lv.size();
            d0 = mon_done;
            run_frame(tbl[0]);
            chk("post_rst_done", mon_done - d0, 1);
            chk_frame("post_rst", 1, q0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
